// File: rtl/rs_fpga_multi.sv
// rs_fpga_multi
//   Reservation station for the FPGA functional unit.
//   - Two dispatch ports (we1/we2) place new entries in the lowest-index free
//     slots. Port 1's entry is older than port 2's entry, and both are younger
//     than every entry already in the station.
//   - Unresolved operands hold their rename tag in src[RRF_SEL-1:0]. They are
//     woken by the NUM_WB writeback buses. When several buses match, the
//     lowest-numbered bus supplies the value.
//   - The oldest ready entry is chosen through an ENT_NUM x ENT_NUM age matrix.
//     The issue_* outputs are combinational and bypass a same-cycle wakeup.
//   - Branch resolution: prmiss squashes entries tagged by specfixtag.
//     prsuccess clears the speculative flag of entries tagged by prtag.
//
// Issue handshake: issue_valid says that the issue_* fields describe a ready
// entry. The entry leaves only on a cycle where issue_valid && issue_ack. If
// issue_valid is low, issue_ack is ignored. issue_valid does not wait for
// issue_ack.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   we1/we2, w*_1, w*_2          dispatch ports (operands, tags, payload)
//   alloc_rdy1/2, free_cnt       free-entry status (free_cnt is registered)
//   wb_valid/kill/dst/rslt       wakeup buses
//   prmiss/prsuccess/prtag/specfixtag  branch resolution
//   issue_*                      selected entry, issue_ack from the exec unit
module rs_fpga_multi #(
   parameter int ENT_NUM     = 4,
   parameter int DATA_LEN    = 32,
   parameter int RRF_SEL     = 6,
   parameter int SPECTAG_LEN = 5,
   parameter int NUM_WB      = 7,
   parameter int PAYLOAD_W   = 64,
   localparam int AW = (ENT_NUM > 1) ? $clog2(ENT_NUM) : 1,
   localparam int CW = $clog2(ENT_NUM + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          we1,
   input  logic                          we2,
   input  logic [DATA_LEN-1:0]           wsrc1_1,
   input  logic [DATA_LEN-1:0]           wsrc2_1,
   input  logic                          wvalid1_1,
   input  logic                          wvalid2_1,
   input  logic [RRF_SEL-1:0]            wrrftag_1,
   input  logic [SPECTAG_LEN-1:0]        wspectag_1,
   input  logic                          wspecbit_1,
   input  logic [PAYLOAD_W-1:0]          wpayload_1,
   input  logic [DATA_LEN-1:0]           wsrc1_2,
   input  logic [DATA_LEN-1:0]           wsrc2_2,
   input  logic                          wvalid1_2,
   input  logic                          wvalid2_2,
   input  logic [RRF_SEL-1:0]            wrrftag_2,
   input  logic [SPECTAG_LEN-1:0]        wspectag_2,
   input  logic                          wspecbit_2,
   input  logic [PAYLOAD_W-1:0]          wpayload_2,
   output logic                          alloc_rdy1,
   output logic                          alloc_rdy2,
   output logic [CW-1:0]                 free_cnt,
   input  logic [NUM_WB-1:0]             wb_valid,
   input  logic [NUM_WB-1:0]             wb_kill,
   input  logic [NUM_WB*RRF_SEL-1:0]     wb_dst,
   input  logic [NUM_WB*DATA_LEN-1:0]    wb_rslt,
   input  logic                          prmiss,
   input  logic                          prsuccess,
   input  logic [SPECTAG_LEN-1:0]        prtag,
   input  logic [SPECTAG_LEN-1:0]        specfixtag,
   output logic                          issue_valid,
   input  logic                          issue_ack,
   output logic [AW-1:0]                 issue_addr,
   output logic [DATA_LEN-1:0]           issue_src1,
   output logic [DATA_LEN-1:0]           issue_src2,
   output logic [RRF_SEL-1:0]            issue_rrftag,
   output logic [SPECTAG_LEN-1:0]        issue_spectag,
   output logic                          issue_specbit,
   output logic [PAYLOAD_W-1:0]          issue_payload
);

   // Entry state
   logic [ENT_NUM-1:0]     busy, valid1, valid2, specbit;
   logic [DATA_LEN-1:0]    src1    [ENT_NUM];
   logic [DATA_LEN-1:0]    src2    [ENT_NUM];
   logic [RRF_SEL-1:0]     rrftag  [ENT_NUM];
   logic [SPECTAG_LEN-1:0] spectag [ENT_NUM];
   logic [PAYLOAD_W-1:0]   payload [ENT_NUM];
   // older[r][c] = 1 when entry r was allocated before entry c.
   // The bit is only meaningful while both entries are busy.
   logic [ENT_NUM-1:0]     older   [ENT_NUM];
   logic [ENT_NUM-1:0]     age_nxt [ENT_NUM];

   logic [NUM_WB-1:0]      wb_live;
   assign wb_live = wb_valid & ~wb_kill;

   // Returns {hit, data}. The buses are scanned from highest to lowest, so the
   // lowest matching bus is the one that wins.
   function automatic logic [DATA_LEN:0] wake_lookup(
      input logic [RRF_SEL-1:0]         tag,
      input logic [NUM_WB-1:0]          live,
      input logic [NUM_WB*RRF_SEL-1:0]  dst,
      input logic [NUM_WB*DATA_LEN-1:0] rslt
   );
      logic [DATA_LEN:0] r;
      r = '0;
      for (int i = NUM_WB - 1; i >= 0; i--) begin
         if (live[i] && (dst[i*RRF_SEL +: RRF_SEL] == tag))
            r = {1'b1, rslt[i*DATA_LEN +: DATA_LEN]};
      end
      return r;
   endfunction

   // Wakeup of resident entries
   logic [ENT_NUM-1:0]  hit1, hit2, wk1, wk2, ready;
   logic [DATA_LEN-1:0] wdat1 [ENT_NUM];
   logic [DATA_LEN-1:0] wdat2 [ENT_NUM];

   always_comb begin
      for (int i = 0; i < ENT_NUM; i++) begin
         {hit1[i], wdat1[i]} = wake_lookup(src1[i][RRF_SEL-1:0], wb_live, wb_dst, wb_rslt);
         {hit2[i], wdat2[i]} = wake_lookup(src2[i][RRF_SEL-1:0], wb_live, wb_dst, wb_rslt);
         wk1[i]   = busy[i] & ~valid1[i] & hit1[i];
         wk2[i]   = busy[i] & ~valid2[i] & hit2[i];
         ready[i] = busy[i] & (valid1[i] | hit1[i]) & (valid2[i] | hit2[i]);
      end
   end

   // Wakeup of operands arriving on the dispatch ports
   logic                p1_hit1, p1_hit2, p2_hit1, p2_hit2;
   logic [DATA_LEN-1:0] p1_dat1, p1_dat2, p2_dat1, p2_dat2;

   always_comb begin
      {p1_hit1, p1_dat1} = wake_lookup(wsrc1_1[RRF_SEL-1:0], wb_live, wb_dst, wb_rslt);
      {p1_hit2, p1_dat2} = wake_lookup(wsrc2_1[RRF_SEL-1:0], wb_live, wb_dst, wb_rslt);
      {p2_hit1, p2_dat1} = wake_lookup(wsrc1_2[RRF_SEL-1:0], wb_live, wb_dst, wb_rslt);
      {p2_hit2, p2_dat2} = wake_lookup(wsrc2_2[RRF_SEL-1:0], wb_live, wb_dst, wb_rslt);
   end

   // Free-slot search: e1 is the lowest free index, e2 the next lowest
   logic [AW-1:0] e1, e2;
   logic          f1, f2;
   logic          alloc1, alloc2, ack;

   always_comb begin
      e1 = '0;
      e2 = '0;
      f1 = 1'b0;
      f2 = 1'b0;
      for (int i = 0; i < ENT_NUM; i++) begin
         if (!busy[i]) begin
            if (!f1) begin
               e1 = AW'(i);
               f1 = 1'b1;
            end else if (!f2) begin
               e2 = AW'(i);
               f2 = 1'b1;
            end
         end
      end
   end

   assign alloc_rdy1 = (free_cnt != '0);
   assign alloc_rdy2 = (free_cnt >= CW'(2));
   // A misprediction drops both dispatch writes for this cycle
   assign alloc1 = we1 & alloc_rdy1 & ~prmiss;
   assign alloc2 = we1 & we2 & alloc_rdy2 & ~prmiss;
   assign ack    = issue_ack & issue_valid;

   // Oldest-ready select
   logic [ENT_NUM-1:0] grant;

   always_comb begin
      issue_addr = '0;
      for (int i = 0; i < ENT_NUM; i++) begin
         grant[i] = ready[i];
         for (int j = 0; j < ENT_NUM; j++) begin
            if (j != i && ready[j] && older[j][i])
               grant[i] = 1'b0;
         end
      end
      for (int i = ENT_NUM - 1; i >= 0; i--) begin
         if (grant[i])
            issue_addr = AW'(i);
      end
   end

   assign issue_valid = |ready;

   always_comb begin
      issue_src1    = '0;
      issue_src2    = '0;
      issue_rrftag  = '0;
      issue_spectag = '0;
      issue_specbit = 1'b0;
      issue_payload = '0;
      if (issue_valid) begin
         issue_src1    = valid1[issue_addr] ? src1[issue_addr] : wdat1[issue_addr];
         issue_src2    = valid2[issue_addr] ? src2[issue_addr] : wdat2[issue_addr];
         issue_rrftag  = rrftag[issue_addr];
         issue_spectag = spectag[issue_addr];
         issue_specbit = specbit[issue_addr] &
                         ~(prsuccess && (spectag[issue_addr] == prtag));
         issue_payload = payload[issue_addr];
      end
   end

   // Next busy vector. free_cnt is derived from it, so an entry that is both
   // acked and squashed in the same cycle is counted only once.
   logic [ENT_NUM-1:0] busy_nxt;
   logic [CW-1:0]      busy_cnt;

   always_comb begin
      busy_nxt = busy;
      if (ack)
         busy_nxt[issue_addr] = 1'b0;
      if (prmiss) begin
         for (int i = 0; i < ENT_NUM; i++) begin
            if ((spectag[i] & specfixtag) != '0)
               busy_nxt[i] = 1'b0;
         end
      end
      if (alloc1)
         busy_nxt[e1] = 1'b1;
      if (alloc2)
         busy_nxt[e2] = 1'b1;
      busy_cnt = '0;
      for (int i = 0; i < ENT_NUM; i++)
         busy_cnt = busy_cnt + CW'(busy_nxt[i]);
   end

   // A new entry becomes younger than every other entry. When both ports
   // allocate, port 1's entry is also older than port 2's entry.
   always_comb begin
      for (int r = 0; r < ENT_NUM; r++) begin
         age_nxt[r] = older[r];
         for (int c = 0; c < ENT_NUM; c++) begin
            if (alloc1 && (AW'(r) == e1))
               age_nxt[r][c] = alloc2 && (AW'(c) == e2);
            else if (alloc2 && (AW'(r) == e2))
               age_nxt[r][c] = 1'b0;
            else if (alloc1 && (AW'(c) == e1))
               age_nxt[r][c] = 1'b1;
            else if (alloc2 && (AW'(c) == e2))
               age_nxt[r][c] = 1'b1;
         end
      end
   end

   // Control state
   always_ff @(posedge clk) begin
      if (reset) begin
         busy     <= '0;
         valid1   <= '0;
         valid2   <= '0;
         specbit  <= '0;
         free_cnt <= CW'(ENT_NUM);
         for (int r = 0; r < ENT_NUM; r++)
            older[r] <= '0;
      end else begin
         busy     <= busy_nxt;
         free_cnt <= CW'(ENT_NUM) - busy_cnt;
         for (int r = 0; r < ENT_NUM; r++)
            older[r] <= age_nxt[r];
         for (int i = 0; i < ENT_NUM; i++) begin
            if (wk1[i]) valid1[i] <= 1'b1;
            if (wk2[i]) valid2[i] <= 1'b1;
            if (prmiss)
               specbit[i] <= 1'b0;
            else if (prsuccess && (spectag[i] == prtag))
               specbit[i] <= 1'b0;
         end
         if (alloc1) begin
            valid1[e1]  <= wvalid1_1 | p1_hit1;
            valid2[e1]  <= wvalid2_1 | p1_hit2;
            specbit[e1] <= wspecbit_1 & ~(prsuccess && (wspectag_1 == prtag));
         end
         if (alloc2) begin
            valid1[e2]  <= wvalid1_2 | p2_hit1;
            valid2[e2]  <= wvalid2_2 | p2_hit2;
            specbit[e2] <= wspecbit_2 & ~(prsuccess && (wspectag_2 == prtag));
         end
      end
   end

   // Entry contents. These are only observed while the busy bit is set, so
   // they need no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < ENT_NUM; i++) begin
         if (wk1[i]) src1[i] <= wdat1[i];
         if (wk2[i]) src2[i] <= wdat2[i];
      end
      if (alloc1) begin
         src1[e1]    <= (wvalid1_1 || !p1_hit1) ? wsrc1_1 : p1_dat1;
         src2[e1]    <= (wvalid2_1 || !p1_hit2) ? wsrc2_1 : p1_dat2;
         rrftag[e1]  <= wrrftag_1;
         spectag[e1] <= wspectag_1;
         payload[e1] <= wpayload_1;
      end
      if (alloc2) begin
         src1[e2]    <= (wvalid1_2 || !p2_hit1) ? wsrc1_2 : p2_dat1;
         src2[e2]    <= (wvalid2_2 || !p2_hit2) ? wsrc2_2 : p2_dat2;
         rrftag[e2]  <= wrrftag_2;
         spectag[e2] <= wspectag_2;
         payload[e2] <= wpayload_2;
      end
   end

endmodule
